// File: rtl/dm_core_mh_if.sv
// dm_core_mh_if: DMI, hart run-control and abstract-register-access signals
// of the multi-hart debug module. The slave modport is the debug module side;
// the master modport is the environment (DTM bridge plus harts).
interface dm_core_mh_if #(
    parameter int unsigned NHARTS = 1,
    parameter int unsigned HW     = (NHARTS > 1) ? $clog2(NHARTS) : 1
);
    // DMI access port
    logic              iDmiReq;
    logic              iDmiWe;
    logic [6:0]        iDmiAddr;
    logic [31:0]       iDmiWData;
    logic              oDmiAck;
    logic [31:0]       oDmiRData;
    // per-hart run control
    logic [NHARTS-1:0] oHaltReq;
    logic [NHARTS-1:0] oResumeReq;
    logic [NHARTS-1:0] iHalted;
    logic [NHARTS-1:0] iResumeAck;
    logic              onRst;
    // abstract register access port
    logic              oArReq;
    logic              oArWrite;
    logic [HW-1:0]     oArHart;
    logic [15:0]       oArRegno;
    logic [31:0]       oArWData;
    logic              iArAck;
    logic              iArErr;
    logic [31:0]       iArRData;

    modport slave (
        input  iDmiReq, iDmiWe, iDmiAddr, iDmiWData,
        output oDmiAck, oDmiRData,
        output oHaltReq, oResumeReq, onRst,
        input  iHalted, iResumeAck,
        output oArReq, oArWrite, oArHart, oArRegno, oArWData,
        input  iArAck, iArErr, iArRData
    );

    modport master (
        output iDmiReq, iDmiWe, iDmiAddr, iDmiWData,
        input  oDmiAck, oDmiRData,
        input  oHaltReq, oResumeReq, onRst,
        output iHalted, iResumeAck,
        input  oArReq, oArWrite, oArHart, oArRegno, oArWData,
        output iArAck, iArErr, iArRData
    );
endinterface

// File: rtl/dm_core_mh.sv
// dm_core_mh: RISC-V debug module core (0.13 register map) for NHARTS harts.
// Decodes DMI accesses, drives per-hart halt/resume requests and ndmreset, and
// runs "access register" abstract commands over the oAr*/iAr* port.
// Optional feature: define DM_AUTOEXEC_EN to implement abstractauto
// (autoexecdata) at DMI address 0x18.
module dm_core_mh #(
    parameter int unsigned NHARTS = 1,
    parameter int unsigned NDATA  = 2,
    parameter int unsigned HW     = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
    input  logic         iClk,
    input  logic         nRst,
    dm_core_mh_if.slave  bus
);

    localparam logic [6:0] A_DATA0     = 7'h04;
    localparam logic [6:0] A_DMCONTROL = 7'h10;
    localparam logic [6:0] A_DMSTATUS  = 7'h11;
    localparam logic [6:0] A_ABSCS     = 7'h16;
    localparam logic [6:0] A_COMMAND   = 7'h17;
    localparam logic [6:0] A_ABSAUTO   = 7'h18;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_dmactive, r_ndmreset;
    logic [9:0]        r_hartsel;
    logic [NHARTS-1:0] r_haltreq, r_resumereq, r_resumeack;
    logic [31:0]       r_data [NDATA];
    logic [2:0]        r_cmderr;
    logic [31:0]       r_cmd;
    logic              r_ar_write;
    logic [HW-1:0]     r_ar_hart;
    logic [15:0]       r_ar_regno;
    logic              r_ack;
    logic [31:0]       r_rdata;
`ifdef DM_AUTOEXEC_EN
    logic [NDATA-1:0]  r_autoexec;
`endif

    logic              w_wr, w_rd, w_busy, w_clr, w_dmc_wr, w_cmd_wr;
    logic              w_sel_exists, w_sel_halted, w_sel_haltreq, w_sel_resumeack;
    logic [HW-1:0]     w_sel_idx;
    logic              w_is_data, w_data_auto, w_auto;
    logic [31:0]       w_data_val;
    logic              w_launch, w_go_req, w_go_done;
    logic [31:0]       w_launch_cmd;
    logic [2:0]        w_launch_err;
    logic [31:0]       w_dmstatus, w_rdata;

    assign w_wr     = bus.iDmiReq & bus.iDmiWe;
    assign w_rd     = bus.iDmiReq & ~bus.iDmiWe;
    assign w_busy   = (r_state != S_IDLE);
    assign w_dmc_wr = w_wr && (bus.iDmiAddr == A_DMCONTROL);
    assign w_cmd_wr = w_wr && (bus.iDmiAddr == A_COMMAND);
    // Clearing dmactive resets the rest of the DM in the very next cycle.
    assign w_clr    = !r_dmactive || (w_dmc_wr && !bus.iDmiWData[0]);

    // Selected-hart lookup; a hartsel beyond NHARTS selects nothing.
    always_comb begin
        w_sel_exists    = 1'b0;
        w_sel_halted    = 1'b0;
        w_sel_haltreq   = 1'b0;
        w_sel_resumeack = 1'b0;
        w_sel_idx       = '0;
        for (int unsigned i = 0; i < NHARTS; i++) begin
            if (r_hartsel == 10'(i)) begin
                w_sel_exists    = 1'b1;
                w_sel_halted    = bus.iHalted[i];
                w_sel_haltreq   = r_haltreq[i];
                w_sel_resumeack = r_resumeack[i];
                w_sel_idx       = HW'(i);
            end
        end
    end

    // dataN address decode, current value and autoexec bit of the addressed word.
    always_comb begin
        w_is_data   = 1'b0;
        w_data_val  = '0;
        w_data_auto = 1'b0;
        for (int unsigned i = 0; i < NDATA; i++) begin
            if (bus.iDmiAddr == 7'(A_DATA0 + i)) begin
                w_is_data  = 1'b1;
                w_data_val = r_data[i];
`ifdef DM_AUTOEXEC_EN
                w_data_auto = r_autoexec[i];
`endif
            end
        end
    end

    assign w_auto       = bus.iDmiReq && w_is_data && w_data_auto && !w_busy && (r_cmderr == 3'd0);
    assign w_launch     = (w_cmd_wr && !w_busy && (r_cmderr == 3'd0)) || w_auto;
    assign w_launch_cmd = w_cmd_wr ? bus.iDmiWData : r_cmd;

    // Command acceptance checks, in priority order.
    always_comb begin
        w_launch_err = 3'd0;
        w_go_req     = 1'b0;
        w_go_done    = 1'b0;
        if (w_launch) begin
            if ((w_launch_cmd[31:24] != 8'd0) || (w_launch_cmd[22:20] != 3'd2))
                w_launch_err = 3'd2;
            else if (!w_sel_exists || !w_sel_halted)
                w_launch_err = 3'd4;
            else if (!w_launch_cmd[17])
                w_go_done = 1'b1;
            else
                w_go_req = 1'b1;
        end
    end

    // Command FSM state register.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Command FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_go_req)       w_state_nxt = S_REQ;
                    else if (w_go_done) w_state_nxt = S_DONE;
                end
                S_REQ:   if (bus.iArAck) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // dmstatus view of the selected hart.
    always_comb begin
        w_dmstatus        = '0;
        w_dmstatus[22]    = 1'b1;
        w_dmstatus[7]     = 1'b1;
        w_dmstatus[3:0]   = 4'd2;
        if (w_sel_exists) begin
            w_dmstatus[17] = w_sel_resumeack;
            w_dmstatus[16] = w_sel_resumeack;
            w_dmstatus[11] = ~w_sel_halted;
            w_dmstatus[10] = ~w_sel_halted;
            w_dmstatus[9]  = w_sel_halted;
            w_dmstatus[8]  = w_sel_halted;
        end else begin
            w_dmstatus[15] = 1'b1;
            w_dmstatus[14] = 1'b1;
        end
    end

    // DMI read data mux.
    always_comb begin
        w_rdata = '0;
        if (w_is_data) begin
            w_rdata = w_data_val;
        end else begin
            case (bus.iDmiAddr)
                A_DMCONTROL: w_rdata = {w_sel_haltreq, 1'b0, 4'd0, r_hartsel, 14'd0, r_ndmreset, r_dmactive};
                A_DMSTATUS:  w_rdata = w_dmstatus;
                A_ABSCS:     w_rdata = {3'd0, 5'd0, 11'd0, w_busy, 1'b0, r_cmderr, 4'd0, 4'(NDATA)};
`ifdef DM_AUTOEXEC_EN
                A_ABSAUTO:   w_rdata = 32'(r_autoexec);
`endif
                default:     w_rdata = '0;
            endcase
        end
    end

    // DMI response, DM registers, hart requests and abstract-command datapath.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_ack       <= 1'b0;
            r_rdata     <= '0;
            r_dmactive  <= 1'b0;
            r_ndmreset  <= 1'b0;
            r_hartsel   <= '0;
            r_haltreq   <= '0;
            r_resumereq <= '0;
            r_resumeack <= '0;
            r_cmderr    <= '0;
            r_cmd       <= '0;
            r_ar_write  <= 1'b0;
            r_ar_hart   <= '0;
            r_ar_regno  <= '0;
            for (int unsigned i = 0; i < NDATA; i++) r_data[i] <= '0;
`ifdef DM_AUTOEXEC_EN
            r_autoexec  <= '0;
`endif
        end else begin
            r_ack   <= bus.iDmiReq;
            r_rdata <= w_rd ? w_rdata : '0;
            if (w_dmc_wr) r_dmactive <= bus.iDmiWData[0];

            if (w_clr) begin
                r_ndmreset  <= 1'b0;
                r_hartsel   <= '0;
                r_haltreq   <= '0;
                r_resumereq <= '0;
                r_resumeack <= '0;
                r_cmderr    <= '0;
                r_cmd       <= '0;
                r_ar_write  <= 1'b0;
                r_ar_hart   <= '0;
                r_ar_regno  <= '0;
                for (int unsigned i = 0; i < NDATA; i++) r_data[i] <= '0;
`ifdef DM_AUTOEXEC_EN
                r_autoexec  <= '0;
`endif
            end else begin
                if (w_dmc_wr) begin
                    r_ndmreset <= bus.iDmiWData[1];
                    r_hartsel  <= bus.iDmiWData[25:16];
                    for (int unsigned i = 0; i < NHARTS; i++)
                        r_haltreq[i] <= (bus.iDmiWData[25:16] == 10'(i)) ? bus.iDmiWData[31] : 1'b0;
                end

                // A resume write beats a same-cycle iResumeAck for its hart.
                for (int unsigned i = 0; i < NHARTS; i++) begin
                    if (w_dmc_wr && (bus.iDmiWData[25:16] == 10'(i)) && bus.iDmiWData[30] &&
                        !bus.iDmiWData[31] && bus.iHalted[i]) begin
                        r_resumereq[i] <= 1'b1;
                        r_resumeack[i] <= 1'b0;
                    end else if (bus.iResumeAck[i]) begin
                        r_resumereq[i] <= 1'b0;
                        r_resumeack[i] <= 1'b1;
                    end
                end

                if (w_wr && !w_busy) begin
                    for (int unsigned i = 0; i < NDATA; i++)
                        if (bus.iDmiAddr == 7'(A_DATA0 + i)) r_data[i] <= bus.iDmiWData;
                end
                if ((r_state == S_REQ) && bus.iArAck && !bus.iArErr && !r_ar_write)
                    r_data[0] <= bus.iArRData;

                // Later assignments take priority: FSM errors override W1C and busy errors.
                if (w_wr && (bus.iDmiAddr == A_ABSCS) && !w_busy)
                    r_cmderr <= r_cmderr & ~bus.iDmiWData[10:8];
                if (w_busy && (r_cmderr == 3'd0) &&
                    ((w_wr && (w_cmd_wr || (bus.iDmiAddr == A_ABSCS) || w_is_data)) || (w_rd && w_is_data)))
                    r_cmderr <= 3'd1;
                if (w_launch_err != 3'd0)
                    r_cmderr <= w_launch_err;
                if ((r_state == S_REQ) && bus.iArAck && bus.iArErr)
                    r_cmderr <= 3'd3;

                if (w_cmd_wr && !w_busy && (r_cmderr == 3'd0))
                    r_cmd <= bus.iDmiWData;
                if (w_go_req) begin
                    r_ar_write <= w_launch_cmd[16];
                    r_ar_regno <= w_launch_cmd[15:0];
                    r_ar_hart  <= w_sel_idx;
                end
`ifdef DM_AUTOEXEC_EN
                if (w_wr && (bus.iDmiAddr == A_ABSAUTO))
                    r_autoexec <= bus.iDmiWData[NDATA-1:0];
`endif
            end
        end
    end

    assign bus.oDmiAck    = r_ack;
    assign bus.oDmiRData  = r_rdata;
    assign bus.oHaltReq   = r_haltreq;
    assign bus.oResumeReq = r_resumereq;
    assign bus.onRst      = ~r_ndmreset;
    assign bus.oArReq     = (r_state == S_REQ);
    assign bus.oArWrite   = r_ar_write;
    assign bus.oArHart    = r_ar_hart;
    assign bus.oArRegno   = r_ar_regno;
    assign bus.oArWData   = r_data[0];

endmodule

// File: tb/tb_dm_core_mh.sv
// tb_dm_core_mh: directed bench for dm_core_mh with NHARTS=4, NDATA=2.
// DMI read expectations are queued when an access is driven and checked when
// the response arrives; run-control and abstract-port outputs are checked
// directly. Exercises abstractauto when DM_AUTOEXEC_EN is defined.
module tb_dm_core_mh;

    localparam int unsigned NH = 4;
    localparam int unsigned ND = 2;

    logic clk;
    logic nRst;

    dm_core_mh_if #(.NHARTS(NH)) bus ();

    dm_core_mh #(.NHARTS(NH), .NDATA(ND)) u_dut (
        .iClk (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;

    logic [31:0] q_exp [$];
    bit          q_rd  [$];
    string       q_tag [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock; every queued DMI access must be answered right after it.
    task automatic tick();
        string       tag;
        logic [31:0] exp;
        bit          rd;
        @(posedge clk);
        #1;
        if (q_tag.size() > 0) begin
            tag = q_tag.pop_front();
            exp = q_exp.pop_front();
            rd  = q_rd.pop_front();
            check({tag, "_ack"}, 32'(bus.oDmiAck), 32'd1);
            if (rd) check(tag, bus.oDmiRData, exp);
        end
    endtask

    task automatic dmi_wr(input logic [6:0] addr, input logic [31:0] data, input string tag);
        bus.iDmiReq   = 1'b1;
        bus.iDmiWe    = 1'b1;
        bus.iDmiAddr  = addr;
        bus.iDmiWData = data;
        q_tag.push_back(tag);
        q_exp.push_back('0);
        q_rd.push_back(1'b0);
        tick();
        bus.iDmiReq   = 1'b0;
        bus.iDmiWe    = 1'b0;
    endtask

    task automatic dmi_rd(input logic [6:0] addr, input logic [31:0] exp, input string tag);
        bus.iDmiReq   = 1'b1;
        bus.iDmiWe    = 1'b0;
        bus.iDmiAddr  = addr;
        bus.iDmiWData = '0;
        q_tag.push_back(tag);
        q_exp.push_back(exp);
        q_rd.push_back(1'b1);
        tick();
        bus.iDmiReq   = 1'b0;
    endtask

    task automatic ar_ack(input logic err, input logic [31:0] rdata);
        bus.iArAck   = 1'b1;
        bus.iArErr   = err;
        bus.iArRData = rdata;
        tick();
        bus.iArAck   = 1'b0;
        bus.iArErr   = 1'b0;
    endtask

    initial begin
        nRst           = 1'b0;
        bus.iDmiReq    = 1'b0;
        bus.iDmiWe     = 1'b0;
        bus.iDmiAddr   = '0;
        bus.iDmiWData  = '0;
        bus.iHalted    = '0;
        bus.iResumeAck = '0;
        bus.iArAck     = 1'b0;
        bus.iArErr     = 1'b0;
        bus.iArRData   = '0;
        repeat (3) tick();

        check("rst_onRst",      32'(bus.onRst),      32'd1);
        check("rst_ack",        32'(bus.oDmiAck),    32'd0);
        check("rst_rdata",      bus.oDmiRData,       32'd0);
        check("rst_haltreq",    32'(bus.oHaltReq),   32'd0);
        check("rst_resumereq",  32'(bus.oResumeReq), 32'd0);
        check("rst_arreq",      32'(bus.oArReq),     32'd0);
        nRst = 1'b1;
        tick();

        dmi_rd(7'h11, 32'h0040_0c82, "dmstatus_reset");
        dmi_wr(7'h10, 32'h0000_0001, "dmactive_on");

        // halt / resume handshake on hart 0
        dmi_wr(7'h10, 32'h8000_0001, "haltreq_wr");
        check("haltreq_set", 32'(bus.oHaltReq), 32'h1);
        bus.iHalted = 4'b0001;
        dmi_rd(7'h11, 32'h0040_0382, "dmstatus_halted");
        dmi_wr(7'h10, 32'h4000_0001, "resumereq_wr");
        check("haltreq_clr", 32'(bus.oHaltReq), 32'h0);
        check("resumereq_set", 32'(bus.oResumeReq), 32'h1);
        tick();
        tick();
        bus.iResumeAck = 4'b0001;
        bus.iHalted    = 4'b0000;
        tick();
        bus.iResumeAck = 4'b0000;
        check("resumereq_clr", 32'(bus.oResumeReq), 32'h0);
        dmi_rd(7'h11, 32'h0043_0c82, "dmstatus_resumeack");

        // abstract read of x5, acked in the fourth REQ cycle
        dmi_wr(7'h10, 32'h8000_0001, "rehalt");
        bus.iHalted = 4'b0001;
        dmi_wr(7'h17, 32'h0022_1005, "cmd_rd_x5");
        check("ar_req",   32'(bus.oArReq),   32'd1);
        check("ar_regno", 32'(bus.oArRegno), 32'h1005);
        check("ar_write", 32'(bus.oArWrite), 32'd0);
        check("ar_hart",  32'(bus.oArHart),  32'd0);
        dmi_rd(7'h16, 32'h0000_1002, "busy_c1");
        check("ar_req_c2", 32'(bus.oArReq), 32'd1);
        dmi_rd(7'h16, 32'h0000_1002, "busy_c2");
        check("ar_req_c3", 32'(bus.oArReq), 32'd1);
        dmi_rd(7'h16, 32'h0000_1002, "busy_c3");
        check("ar_req_c4", 32'(bus.oArReq), 32'd1);
        bus.iArAck   = 1'b1;
        bus.iArRData = 32'hDEAD_BEEF;
        dmi_rd(7'h16, 32'h0000_1002, "busy_c4");
        bus.iArAck   = 1'b0;
        check("ar_req_done", 32'(bus.oArReq), 32'd0);
        dmi_rd(7'h16, 32'h0000_1002, "busy_c5");
        dmi_rd(7'h16, 32'h0000_0002, "busy_end");
        dmi_rd(7'h04, 32'hDEAD_BEEF, "data0_rd");

        // hart running -> cmderr 4, W1C clears it
        bus.iHalted = 4'b0000;
        dmi_wr(7'h17, 32'h0022_1005, "cmd_running");
        check("no_req_running", 32'(bus.oArReq), 32'd0);
        dmi_rd(7'h16, 32'h0000_0402, "cmderr4");
        dmi_wr(7'h16, 32'h0000_0700, "w1c_4");
        dmi_rd(7'h16, 32'h0000_0002, "cmderr4_clr");

        // command while busy -> cmderr 1, original command continues
        bus.iHalted = 4'b0001;
        dmi_wr(7'h17, 32'h0022_1005, "cmd_first");
        dmi_wr(7'h17, 32'h0022_1007, "cmd_while_busy");
        check("busy_cmd_ignored", 32'(bus.oArRegno), 32'h1005);
        check("busy_req_held", 32'(bus.oArReq), 32'd1);
        ar_ack(1'b0, 32'h1111_1111);
        tick();
        dmi_rd(7'h16, 32'h0000_0102, "cmderr1");
        dmi_wr(7'h16, 32'h0000_0700, "w1c_1");

        // aarsize 3 -> cmderr 2
        dmi_wr(7'h17, 32'h0032_1005, "cmd_aarsize3");
        check("no_req_aarsize", 32'(bus.oArReq), 32'd0);
        dmi_rd(7'h16, 32'h0000_0202, "cmderr2");
        dmi_wr(7'h16, 32'h0000_0700, "w1c_2");

        // access fault with a W1C in the same cycle -> cmderr 3, data0 untouched
        dmi_wr(7'h04, 32'h1234_5678, "data0_wr");
        dmi_wr(7'h17, 32'h0022_1005, "cmd_err");
        bus.iArAck   = 1'b1;
        bus.iArErr   = 1'b1;
        bus.iArRData = 32'hBAD0_BAD0;
        dmi_wr(7'h16, 32'h0000_0700, "w1c_during_err");
        bus.iArAck   = 1'b0;
        bus.iArErr   = 1'b0;
        tick();
        dmi_rd(7'h16, 32'h0000_0302, "cmderr3");
        dmi_rd(7'h04, 32'h1234_5678, "data0_kept");
        dmi_wr(7'h16, 32'h0000_0700, "w1c_3");

        // abstract write of x6 from data0
        dmi_wr(7'h17, 32'h0023_1006, "cmd_wr_x6");
        check("arw_write", 32'(bus.oArWrite), 32'd1);
        check("arw_wdata", bus.oArWData, 32'h1234_5678);
        check("arw_regno", 32'(bus.oArRegno), 32'h1006);
        ar_ack(1'b0, 32'hFFFF_FFFF);
        tick();
        dmi_rd(7'h04, 32'h1234_5678, "data0_after_wr");

        // transfer=0: busy for exactly one cycle, no port request
        dmi_wr(7'h17, 32'h0020_0000, "cmd_notransfer");
        check("notransfer_noreq", 32'(bus.oArReq), 32'd0);
        dmi_rd(7'h16, 32'h0000_1002, "notransfer_busy");
        dmi_rd(7'h16, 32'h0000_0002, "notransfer_idle");

        // hart selection
        dmi_wr(7'h10, 32'h8005_0001, "hartsel5");
        check("haltreq_nonexist", 32'(bus.oHaltReq), 32'h0);
        dmi_rd(7'h11, 32'h0040_c082, "dmstatus_nonexist");
        dmi_rd(7'h10, 32'h0005_0001, "dmcontrol_rb5");
        dmi_wr(7'h10, 32'h8002_0001, "hartsel2");
        check("haltreq_hart2", 32'(bus.oHaltReq), 32'h4);
        dmi_rd(7'h10, 32'h8002_0001, "dmcontrol_rb2");

        // ndmreset
        dmi_wr(7'h10, 32'h0000_0003, "ndmreset_on");
        check("onRst_low", 32'(bus.onRst), 32'd0);
        dmi_wr(7'h10, 32'h0000_0001, "ndmreset_off");
        check("onRst_high", 32'(bus.onRst), 32'd1);

        // resume request colliding with iResumeAck; resume to a running hart
        dmi_wr(7'h10, 32'h4000_0001, "resume_a");
        check("resume_a_req", 32'(bus.oResumeReq), 32'h1);
        bus.iResumeAck = 4'b0001;
        tick();
        bus.iResumeAck = 4'b0001;
        dmi_wr(7'h10, 32'h4000_0001, "resume_collide");
        bus.iResumeAck = 4'b0000;
        check("collide_req", 32'(bus.oResumeReq), 32'h1);
        dmi_rd(7'h11, 32'h0040_0382, "collide_ackclr");
        bus.iResumeAck = 4'b0001;
        tick();
        bus.iResumeAck = 4'b0000;
        bus.iHalted    = 4'b0000;
        dmi_wr(7'h10, 32'h4000_0001, "resume_running");
        check("resume_running_ign", 32'(bus.oResumeReq), 32'h0);

        // dmactive dropped mid-REQ: request withdrawn, late ack ignored
        bus.iHalted = 4'b0001;
        dmi_wr(7'h17, 32'h0022_1005, "cmd_before_deact");
        check("deact_req_up", 32'(bus.oArReq), 32'd1);
        dmi_wr(7'h10, 32'h0000_0000, "deactivate");
        check("deact_req_drop", 32'(bus.oArReq), 32'd0);
        ar_ack(1'b0, 32'h0000_0055);
        dmi_wr(7'h10, 32'h0000_0001, "reactivate");
        dmi_rd(7'h04, 32'h0000_0000, "data0_after_deact");
        dmi_rd(7'h16, 32'h0000_0002, "abscs_after_deact");

`ifdef DM_AUTOEXEC_EN
        dmi_wr(7'h17, 32'h0023_1006, "auto_cmd");
        check("auto_cmd_req", 32'(bus.oArReq), 32'd1);
        ar_ack(1'b0, 32'h0);
        tick();
        dmi_wr(7'h18, 32'h0000_0001, "abstractauto_wr");
        dmi_rd(7'h18, 32'h0000_0001, "abstractauto_rb");
        dmi_wr(7'h04, 32'hCAFE_F00D, "data0_autoexec");
        check("autoexec_req",   32'(bus.oArReq),   32'd1);
        check("autoexec_wdata", bus.oArWData,      32'hCAFE_F00D);
        check("autoexec_regno", 32'(bus.oArRegno), 32'h1006);
        ar_ack(1'b0, 32'h0);
        tick();
`else
        dmi_wr(7'h18, 32'h0000_0001, "abstractauto_wr");
        dmi_rd(7'h18, 32'h0000_0000, "abstractauto_absent");
        dmi_wr(7'h04, 32'hCAFE_F00D, "data0_noauto");
        check("noauto_req", 32'(bus.oArReq), 32'd0);
`endif

        check("sb_drained", 32'(q_tag.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
